// File: rtl/o_fab_serializer_pkg.sv
// Shared types and helpers for the fabric-to-pad output serializer.
// Used by o_fab_serializer (optional parity via O_FAB_SERIALIZER_PARITY_EN).
package o_fab_serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam int WIDTH_MIN = 3;
  localparam int WIDTH_MAX = 10;

  // Even parity: the appended bit makes the total count of ones even.
  function automatic logic even_parity(input logic [WIDTH_MAX-1:0] word);
    return ^word;
  endfunction

endpackage

// File: rtl/o_fab_shift_reg.sv
// Loadable right-shift register; load wins over shift, LSB is the next bit out.
module o_fab_shift_reg #(
  parameter int W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift,
  input  logic [W-1:0] d,
  output logic         lsb
);

  logic [W-1:0] data_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_reg <= '0;
    end else if (load) begin
      data_reg <= d;
    end else if (shift) begin
      data_reg <= {1'b0, data_reg[W-1:1]};
    end
  end

  assign lsb = data_reg[0];

endmodule

// File: rtl/o_fab_serializer.sv
// Fabric-to-pad output serializer: parallel word in over valid/ready, LSB-first serial out.
// Define O_FAB_SERIALIZER_PARITY_EN to append an even-parity bit to every frame.
module o_fab_serializer
  import o_fab_serializer_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] D,
  input  logic             DATA_VALID,
  output logic             DATA_READY,
  input  logic             OE_IN,
  output logic             Q,
  output logic             OE_OUT
);

`ifdef O_FAB_SERIALIZER_PARITY_EN
  localparam int FRAME_LEN = WIDTH + 1;
`else
  localparam int FRAME_LEN = WIDTH;
`endif
  localparam int CNT_W = $clog2(WIDTH + 2);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_LEN - 1);

  generate
    if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
      $error("o_fab_serializer: WIDTH out of range");
    end
  endgenerate

  state_t                 state_reg;
  logic [CNT_W-1:0]       cnt_reg;
  logic                   oe_latch_reg;
  logic                   accept;
  logic                   bit_out;
  logic [FRAME_LEN-1:0]   load_word;

`ifdef O_FAB_SERIALIZER_PARITY_EN
  assign load_word = {even_parity(WIDTH_MAX'(D)), D};
`else
  assign load_word = D;
`endif

  // Ready in IDLE or on the final bit of a frame, so frames can chain with no gap.
  assign DATA_READY = ~RST & ((state_reg == IDLE) | (cnt_reg == LAST_BIT));
  assign accept     = DATA_VALID & DATA_READY;

  o_fab_shift_reg #(
    .W (FRAME_LEN)
  ) u_shift_reg (
    .clk   (CLK),
    .rst   (RST),
    .load  (accept),
    .shift (state_reg == SHIFT),
    .d     (load_word),
    .lsb   (bit_out)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      oe_latch_reg <= 1'b0;
      Q            <= 1'b0;
      OE_OUT       <= 1'b0;
    end else begin
      // Output stage lags the shift register by one edge.
      Q      <= (state_reg == SHIFT) ? bit_out : 1'b0;
      OE_OUT <= (state_reg == SHIFT) ? oe_latch_reg : 1'b0;
      if (accept) begin
        state_reg    <= SHIFT;
        cnt_reg      <= '0;
        oe_latch_reg <= OE_IN;
      end else if (state_reg == SHIFT) begin
        if (cnt_reg == LAST_BIT) begin
          state_reg <= IDLE;
          cnt_reg   <= '0;
        end else begin
          cnt_reg <= cnt_reg + CNT_W'(1);
        end
      end
    end
  end

endmodule
